// File: rtl/systolic_operand_feeder_os_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic operand feeder.
package systolic_operand_feeder_os_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  localparam int FLUSH_CYCLES = 2;

  function automatic int feed_cycles(input int k_dim, input int rows, input int cols);
    return k_dim + rows + cols - 2;
  endfunction

  // Index width that stays at least one bit wide for single-row/column arrays.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_operand_feeder_os_feeder_skew_lane.sv
// One skewed lane: selects word (n - offset) of a K_DIM-word vector when in range.
module feeder_skew_lane
  import systolic_operand_feeder_os_pkg::*;
#(
  parameter int K_DIM     = 4,
  parameter int WORD_SIZE = 16,
  parameter int CW        = 4
) (
  input  logic                       en,
  input  logic [CW-1:0]              n,
  input  logic [CW-1:0]              offset,
  input  logic [K_DIM*WORD_SIZE-1:0] vec,
  output logic [WORD_SIZE-1:0]       word,
  output logic                       valid
);

  logic [CW-1:0] diff;

  always_comb begin
    word  = '0;
    valid = 1'b0;
    diff  = n - offset;
    // diff is only meaningful once n >= offset, so wrap-around never aliases.
    if (en && (n >= offset) && (diff < CW'(K_DIM))) begin
      valid = 1'b1;
      for (int unsigned k = 0; k < K_DIM; k++) begin
        if (diff == CW'(k)) word = vec[k*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

endmodule

// File: rtl/systolic_operand_feeder_os.sv
// Diagonally skewed A/B operand feeder for an output-stationary systolic array.
// Optional RU operand mirroring is enabled by defining RU_OPERAND_TAP_EN.
module systolic_operand_feeder_os
  import systolic_operand_feeder_os_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int K_DIM     = 4,
  parameter int WORD_SIZE = 16,
  parameter int NUM_RU    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ROWS*K_DIM*WORD_SIZE-1:0] input_matrix,
  input  logic [K_DIM*COLS*WORD_SIZE-1:0] weight_matrix,
  output logic                            busy,
  output logic [ROWS*WORD_SIZE-1:0]       left_out,
  output logic [ROWS-1:0]                 left_valid,
  output logic [COLS*WORD_SIZE-1:0]       top_out,
  output logic [COLS-1:0]                 top_valid,
  output logic                            done
`ifdef RU_OPERAND_TAP_EN
  ,
  input  logic [NUM_RU-1:0]                      ru_enable,
  input  logic [idx_width(ROWS)*NUM_RU-1:0]      ru_row_mapping,
  input  logic [idx_width(COLS)*NUM_RU-1:0]      ru_col_mapping,
  output logic [NUM_RU*WORD_SIZE-1:0]            ru_left_out,
  output logic [NUM_RU*WORD_SIZE-1:0]            ru_top_out,
  output logic [NUM_RU-1:0]                      ru_operand_valid
`endif
);

  localparam int FEED_CYCLES = feed_cycles(K_DIM, ROWS, COLS);
  localparam int CW          = $clog2(FEED_CYCLES + 1);
  localparam int AW          = ROWS * K_DIM * WORD_SIZE;
  localparam int BW          = K_DIM * COLS * WORD_SIZE;
  localparam int VW          = K_DIM * WORD_SIZE;

  feeder_state_t state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [AW-1:0] a_q, a_d;
  logic [BW-1:0] b_q, b_d;

  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [ROWS*WORD_SIZE-1:0] left_out_q, left_out_d;
  logic [ROWS-1:0]           left_valid_q, left_valid_d;
  logic [COLS*WORD_SIZE-1:0] top_out_q, top_out_d;
  logic [COLS-1:0]           top_valid_q, top_valid_d;

  logic feeding;
  logic [VW-1:0] col_vec [COLS];

  assign feeding = (state_q == FEED);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = input_matrix;
          b_d     = weight_matrix;
          n_d     = '0;
          state_d = FEED;
        end
      end
      FEED: begin
        if (n_q == CW'(FEED_CYCLES - 1)) begin
          n_d     = '0;
          state_d = FLUSH;
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      FLUSH: begin
        if (n_q == CW'(FLUSH_CYCLES - 1)) begin
          n_d     = '0;
          state_d = DONE;
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Column c of B is strided in the flat bus; gather it into a contiguous vector.
  always_comb begin
    for (int unsigned c = 0; c < COLS; c++) begin
      col_vec[c] = '0;
      for (int unsigned k = 0; k < K_DIM; k++) begin
        col_vec[c][k*WORD_SIZE +: WORD_SIZE] = b_q[(k*COLS + c)*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    feeder_skew_lane #(.K_DIM(K_DIM), .WORD_SIZE(WORD_SIZE), .CW(CW)) u_lane (
      .en     (feeding),
      .n      (n_q),
      .offset (CW'(r)),
      .vec    (a_q[r*VW +: VW]),
      .word   (left_out_d[r*WORD_SIZE +: WORD_SIZE]),
      .valid  (left_valid_d[r])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    feeder_skew_lane #(.K_DIM(K_DIM), .WORD_SIZE(WORD_SIZE), .CW(CW)) u_lane (
      .en     (feeding),
      .n      (n_q),
      .offset (CW'(c)),
      .vec    (col_vec[c]),
      .word   (top_out_d[c*WORD_SIZE +: WORD_SIZE]),
      .valid  (top_valid_d[c])
    );
  end

  assign busy_d = (state_q != IDLE);
  assign done_d = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      left_out_q   <= '0;
      left_valid_q <= '0;
      top_out_q    <= '0;
      top_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      left_out_q   <= left_out_d;
      left_valid_q <= left_valid_d;
      top_out_q    <= top_out_d;
      top_valid_q  <= top_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign left_out   = left_out_q;
  assign left_valid = left_valid_q;
  assign top_out    = top_out_q;
  assign top_valid  = top_valid_q;

`ifdef RU_OPERAND_TAP_EN
  localparam int RW = idx_width(ROWS);
  localparam int CLW = idx_width(COLS);

  logic [RW*NUM_RU-1:0]  ru_row_q, ru_row_d;
  logic [CLW*NUM_RU-1:0] ru_col_q, ru_col_d;
  logic [VW-1:0]         ru_avec [NUM_RU];
  logic [VW-1:0]         ru_bvec [NUM_RU];
  logic [CW-1:0]         ru_off  [NUM_RU];

  logic [NUM_RU*WORD_SIZE-1:0] ru_left_out_q, ru_left_out_d;
  logic [NUM_RU*WORD_SIZE-1:0] ru_top_out_q, ru_top_out_d;
  logic [NUM_RU-1:0]           ru_valid_q, ru_valid_d;
  logic [NUM_RU-1:0]           ru_a_valid, ru_b_valid;

  always_comb begin
    ru_row_d = ru_row_q;
    ru_col_d = ru_col_q;
    if (state_q == IDLE && start) begin
      ru_row_d = ru_row_mapping;
      ru_col_d = ru_col_mapping;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_RU; i++) begin
      ru_avec[i] = '0;
      ru_bvec[i] = '0;
      ru_off[i]  = CW'(ru_row_q[i*RW +: RW]) + CW'(ru_col_q[i*CLW +: CLW]);
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (ru_row_q[i*RW +: RW] == RW'(r)) ru_avec[i] = a_q[r*VW +: VW];
      end
      for (int unsigned c = 0; c < COLS; c++) begin
        if (ru_col_q[i*CLW +: CLW] == CLW'(c)) ru_bvec[i] = col_vec[c];
      end
    end
  end

  for (genvar i = 0; i < NUM_RU; i++) begin : g_ru
    feeder_skew_lane #(.K_DIM(K_DIM), .WORD_SIZE(WORD_SIZE), .CW(CW)) u_lane_a (
      .en     (feeding && ru_enable[i]),
      .n      (n_q),
      .offset (ru_off[i]),
      .vec    (ru_avec[i]),
      .word   (ru_left_out_d[i*WORD_SIZE +: WORD_SIZE]),
      .valid  (ru_a_valid[i])
    );
    feeder_skew_lane #(.K_DIM(K_DIM), .WORD_SIZE(WORD_SIZE), .CW(CW)) u_lane_b (
      .en     (feeding && ru_enable[i]),
      .n      (n_q),
      .offset (ru_off[i]),
      .vec    (ru_bvec[i]),
      .word   (ru_top_out_d[i*WORD_SIZE +: WORD_SIZE]),
      .valid  (ru_b_valid[i])
    );
    assign ru_valid_d[i] = ru_a_valid[i] & ru_b_valid[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ru_row_q      <= '0;
      ru_col_q      <= '0;
      ru_left_out_q <= '0;
      ru_top_out_q  <= '0;
      ru_valid_q    <= '0;
    end else begin
      ru_row_q      <= ru_row_d;
      ru_col_q      <= ru_col_d;
      ru_left_out_q <= ru_left_out_d;
      ru_top_out_q  <= ru_top_out_d;
      ru_valid_q    <= ru_valid_d;
    end
  end

  assign ru_left_out      = ru_left_out_q;
  assign ru_top_out       = ru_top_out_q;
  assign ru_operand_valid = ru_valid_q;
`endif

endmodule

// File: tb/tb_systolic_operand_feeder_os.sv
// Directed bench for systolic_operand_feeder_os with a golden skew model.
module tb_systolic_operand_feeder_os;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int K    = 4;
  localparam int W    = 16;
  localparam int NRU  = 4;
  localparam int FEED = K + ROWS + COLS - 2;
  localparam int NCAP = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [ROWS*K*W-1:0] input_matrix = '0;
  logic [K*COLS*W-1:0] weight_matrix = '0;
  logic busy, done;
  logic [ROWS*W-1:0] left_out;
  logic [ROWS-1:0]   left_valid;
  logic [COLS*W-1:0] top_out;
  logic [COLS-1:0]   top_valid;
`ifdef RU_OPERAND_TAP_EN
  logic [NRU-1:0]   ru_enable = 4'b0011;
  logic [2*NRU-1:0] ru_row_mapping = '0;
  logic [2*NRU-1:0] ru_col_mapping = '0;
  logic [NRU*W-1:0] ru_left_out, ru_top_out;
  logic [NRU-1:0]   ru_operand_valid;
`endif

  systolic_operand_feeder_os #(.ROWS(ROWS), .COLS(COLS), .K_DIM(K), .WORD_SIZE(W), .NUM_RU(NRU)) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_matrix(input_matrix), .weight_matrix(weight_matrix),
    .busy(busy), .left_out(left_out), .left_valid(left_valid),
    .top_out(top_out), .top_valid(top_valid), .done(done)
`ifdef RU_OPERAND_TAP_EN
    , .ru_enable(ru_enable), .ru_row_mapping(ru_row_mapping), .ru_col_mapping(ru_col_mapping),
    .ru_left_out(ru_left_out), .ru_top_out(ru_top_out), .ru_operand_valid(ru_operand_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ROWS*K*W-1:0] a_mat, a_alt;
  logic [K*COLS*W-1:0] b_mat;

  logic [ROWS*W-1:0] cap_left [NCAP];
  logic [ROWS-1:0]   cap_lv   [NCAP];
  logic [COLS*W-1:0] cap_top  [NCAP];
  logic [COLS-1:0]   cap_tv   [NCAP];
  logic              cap_busy [NCAP];
  logic              cap_done [NCAP];
`ifdef RU_OPERAND_TAP_EN
  logic [NRU*W-1:0]  cap_rl   [NCAP];
  logic [NRU*W-1:0]  cap_rt   [NCAP];
  logic [NRU-1:0]    cap_rv   [NCAP];
`endif

  typedef struct {
    int          n;
    logic [3:0]  lv;
    logic [3:0]  tv;
    int          row;
    logic [15:0] lw;
    int          col;
    logic [15:0] tw;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [ROWS*W-1:0] gold_left(input logic [ROWS*K*W-1:0] a, input int n);
    logic [ROWS*W-1:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      if (n - r >= 0 && n - r < K) v[r*W +: W] = a[(r*K + n - r)*W +: W];
    return v;
  endfunction

  function automatic logic [ROWS-1:0] gold_lv(input int n);
    logic [ROWS-1:0] v = '0;
    for (int r = 0; r < ROWS; r++) v[r] = (n - r >= 0 && n - r < K);
    return v;
  endfunction

  function automatic logic [COLS*W-1:0] gold_top(input logic [K*COLS*W-1:0] b, input int n);
    logic [COLS*W-1:0] v = '0;
    for (int c = 0; c < COLS; c++)
      if (n - c >= 0 && n - c < K) v[c*W +: W] = b[((n - c)*COLS + c)*W +: W];
    return v;
  endfunction

  function automatic logic [COLS-1:0] gold_tv(input int n);
    logic [COLS-1:0] v = '0;
    for (int c = 0; c < COLS; c++) v[c] = (n - c >= 0 && n - c < K);
    return v;
  endfunction

  task automatic capture(input int i);
    cap_left[i] = left_out;  cap_lv[i] = left_valid;
    cap_top[i]  = top_out;   cap_tv[i] = top_valid;
    cap_busy[i] = busy;      cap_done[i] = done;
`ifdef RU_OPERAND_TAP_EN
    cap_rl[i] = ru_left_out; cap_rt[i] = ru_top_out; cap_rv[i] = ru_operand_valid;
`endif
  endtask

  // Pulse (or hold) start, then capture ncap cycles beginning with the n=0 output cycle.
  task automatic run_capture(input int ncap, input bit hold);
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!hold) start = 1'b0;
    for (int i = 0; i < ncap; i++) begin
      @(negedge clk);
      capture(i);
      if (hold && i == 4) input_matrix = a_alt;
    end
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_valids"}, 64'({left_valid, top_valid}), 64'd0);
    check({tag, "_data"}, {left_out, top_out}, 64'd0);
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < K; k++) begin
        a_mat[(r*K + k)*W +: W] = 16'(16*r + k);
        a_alt[(r*K + k)*W +: W] = 16'(16'h0800 + 16*r + k + 5);
      end
    for (int k = 0; k < K; k++)
      for (int c = 0; c < COLS; c++) b_mat[(k*COLS + c)*W +: W] = 16'(16'h0100 + 16*k + c);
    input_matrix  = a_mat;
    weight_matrix = b_mat;
`ifdef RU_OPERAND_TAP_EN
    ru_row_mapping[1:0] = 2'd1; ru_col_mapping[1:0] = 2'd2;
    ru_row_mapping[3:2] = 2'd2; ru_col_mapping[3:2] = 2'd0;
    ru_enable = 4'b0001;
`endif

    vecs[0] = '{n:0,  lv:4'b0001, tv:4'b0001, row:0, lw:16'h0000, col:0, tw:16'h0100};
    vecs[1] = '{n:1,  lv:4'b0011, tv:4'b0011, row:1, lw:16'h0010, col:1, tw:16'h0101};
    vecs[2] = '{n:3,  lv:4'b1111, tv:4'b1111, row:0, lw:16'h0003, col:3, tw:16'h0103};
    vecs[3] = '{n:3,  lv:4'b1111, tv:4'b1111, row:3, lw:16'h0030, col:0, tw:16'h0130};
    vecs[4] = '{n:6,  lv:4'b1000, tv:4'b1000, row:3, lw:16'h0033, col:3, tw:16'h0133};
    vecs[5] = '{n:9,  lv:4'b0000, tv:4'b0000, row:3, lw:16'h0000, col:3, tw:16'h0000};
    vecs[6] = '{n:10, lv:4'b0000, tv:4'b0000, row:0, lw:16'h0000, col:0, tw:16'h0000};
    vecs[7] = '{n:11, lv:4'b0000, tv:4'b0000, row:2, lw:16'h0000, col:2, tw:16'h0000};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    // Single run: table vectors, golden model every cycle, busy/done timeline.
    run_capture(FEED + 4, 1'b0);
    foreach (vecs[j]) begin
      check($sformatf("vec%0d_lv", j), 64'(cap_lv[vecs[j].n]), 64'(vecs[j].lv));
      check($sformatf("vec%0d_tv", j), 64'(cap_tv[vecs[j].n]), 64'(vecs[j].tv));
      check($sformatf("vec%0d_left", j), 64'(cap_left[vecs[j].n][vecs[j].row*W +: W]), 64'(vecs[j].lw));
      check($sformatf("vec%0d_top", j), 64'(cap_top[vecs[j].n][vecs[j].col*W +: W]), 64'(vecs[j].tw));
    end
    for (int i = 0; i < FEED + 2; i++) begin
      check($sformatf("gold_left_n%0d", i), 64'(cap_left[i]), 64'(gold_left(a_mat, i)));
      check($sformatf("gold_top_n%0d", i), 64'(cap_top[i]), 64'(gold_top(b_mat, i)));
      check($sformatf("gold_valid_n%0d", i), 64'({cap_lv[i], cap_tv[i]}), 64'({gold_lv(i), gold_tv(i)}));
    end
    for (int i = 0; i < FEED + 4; i++) begin
      check($sformatf("done_c%0d", i), 64'(cap_done[i]), 64'(i == FEED + 2));
      check($sformatf("busy_c%0d", i), 64'(cap_busy[i]), 64'(i <= FEED + 2));
    end
`ifdef RU_OPERAND_TAP_EN
    check("ru0_n3_left", 64'(cap_rl[3][W-1:0]), 64'h0010);
    check("ru0_n3_top",  64'(cap_rt[3][W-1:0]), 64'h0102);
    check("ru0_n3_valid", 64'(cap_rv[3][0]), 64'd1);
    check("ru0_n6_left", 64'(cap_rl[6][W-1:0]), 64'h0013);
    check("ru0_n6_top",  64'(cap_rt[6][W-1:0]), 64'h0132);
    check("ru0_n7_valid", 64'(cap_rv[7][0]), 64'd0);
    check("ru0_n2_valid", 64'(cap_rv[2][0]), 64'd0);
    for (int i = 0; i < FEED + 4; i++)
      check($sformatf("ru1_off_c%0d", i), 64'(cap_rv[i][3:1]), 64'd0);
`endif

    // start held through the run with A changed mid-run; rerun only from IDLE with the new A.
    run_capture(FEED + 6, 1'b1);
    for (int i = 0; i < FEED + 2; i++)
      check($sformatf("hold_left_n%0d", i), 64'(cap_left[i]), 64'(gold_left(a_mat, i)));
    check("hold_done", 64'(cap_done[FEED + 2]), 64'd1);
    check("hold_done_once", 64'(cap_done[FEED + 1] | cap_done[FEED + 3]), 64'd0);
    check("hold_gap_busy", 64'(cap_busy[FEED + 3]), 64'd0);
    check("b2b_n0_row0", 64'(cap_left[FEED + 4][W-1:0]), 64'(a_alt[W-1:0]));
    check("b2b_n0_lv", 64'(cap_lv[FEED + 4]), 64'(gold_lv(0)));
    check("b2b_n1", 64'(cap_left[FEED + 5]), 64'(gold_left(a_alt, 1)));
    repeat (FEED + 4) @(negedge clk);
    check_idle_outputs("b2b_end");

    // Synchronous reset while the state counter is at n=5.
    input_matrix = a_mat;
    run_capture(5, 1'b0);
    check("prerst_n4", 64'(cap_left[4]), 64'(gold_left(a_mat, 4)));
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("midrst_no_done", 64'(seen), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_operand_feeder_os.md
# systolic_operand_feeder_os

Streams a latched input matrix A (ROWS×K_DIM) and weight matrix B (K_DIM×COLS) into the left and top edges of the output-stationary systolic array with diagonal skew: row r is delayed r cycles, column c is delayed c cycles. It sits upstream of the array, on the opposite side from the output-matrix collector. It sequences one full matmul per start request and pulses done once every PE has received its last operand pair. Optionally, it mirrors the operand pair of each remapped faulty PE to the redundant recompute units.

## Interface
- ROWS, 4, array rows
- COLS, 4, array columns
- K_DIM, 4, inner dimension (operands per PE)
- WORD_SIZE, 16, operand width
- NUM_RU, 4, redundant units (used only with RU_OPERAND_TAP_EN)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request a matmul; accepted only in IDLE
- input_matrix  in  ROWS*K_DIM*WORD_SIZE  A[r][k] at word index r*K_DIM+k
- weight_matrix  in  K_DIM*COLS*WORD_SIZE  B[k][c] at word index k*COLS+c
- busy  out  1  high in FEED/FLUSH/DONE
- left_out  out  ROWS*WORD_SIZE  left-edge operand, word r to row r
- left_valid  out  ROWS  per-row operand valid
- top_out  out  COLS*WORD_SIZE  top-edge operand, word c to column c
- top_valid  out  COLS  per-column operand valid
- done  out  1  one-cycle completion pulse
- With RU_OPERAND_TAP_EN only:
  - ru_enable  in  NUM_RU  RU i active
  - ru_row_mapping  in  clog2(ROWS)*NUM_RU  faulty-PE row per RU
  - ru_col_mapping  in  clog2(COLS)*NUM_RU  faulty-PE column per RU
  - ru_left_out  out  NUM_RU*WORD_SIZE  A operand for RU i
  - ru_top_out  out  NUM_RU*WORD_SIZE  B operand for RU i
  - ru_operand_valid  out  NUM_RU  RU i operands valid

## Operation
- States are IDLE → FEED → FLUSH → DONE → IDLE.
- IDLE: on start, latch both matrices into internal registers, clear step counter n, go to FEED. Later changes on matrix inputs have no effect.
- FEED: runs for FEED_CYCLES = K_DIM+ROWS+COLS-2 cycles, with n = 0..FEED_CYCLES-1.
  - Row r: if 0 ≤ n-r < K_DIM, then left_out[r] = A[r][n-r] and left_valid[r] = 1. Otherwise the word is 0 and valid is 0.
  - Column c: if 0 ≤ n-c < K_DIM, then top_out[c] = B[n-c][c] and top_valid[c] = 1. Otherwise the word is 0 and valid is 0.
  - The cycles after the last edge operand keep the edges at 0 and invalid while operands propagate to PE(ROWS-1,COLS-1).
- FLUSH: 2 cycles with all edge outputs at 0 and invalid, covering the double-buffered MAC output hold.
- DONE: 1 cycle with done=1, then IDLE.
- start is ignored in every state except IDLE, including DONE.
- Counter width is clog2(FEED_CYCLES+1). Index subtraction is signed or range-checked, with no wrap-around aliasing.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, all *_valid=0, all data outputs=0, state=IDLE, n=0.
- start accepted at edge T → first FEED cycle outputs (n=0) are visible after edge T+1.
- done is visible FEED_CYCLES+2 cycles after the first FEED cycle.
- Minimum start-to-start interval is FEED_CYCLES+4 cycles.
- rst mid-operation → next cycle in IDLE with all outputs at reset values. No done pulse.
- Degenerate sizes (ROWS=COLS=K_DIM=1): FEED_CYCLES=1.

## Configuration
- RU_OPERAND_TAP_EN defined:
  - For each RU i with ru_enable[i]=1, mapped to PE (r,c): while in FEED with 0 ≤ n-r-c < K_DIM, ru_left_out[i] = A[r][n-r-c], ru_top_out[i] = B[n-r-c][c], and ru_operand_valid[i] = 1. This is the same cycle the faulty PE sees that pair.
  - Otherwise these outputs are 0 and invalid.
  - Mappings are sampled on start and held for the run.
- RU_OPERAND_TAP_EN undefined: the RU ports and logic are absent. The edge behaviour is identical.

## Structure
- The shared package holds the state enum (IDLE/FEED/FLUSH/DONE), FLUSH_CYCLES=2, and a FEED_CYCLES function of (K_DIM,ROWS,COLS).
- One sub-module, feeder_skew_lane: given n, a lane offset, and a K_DIM-word vector, it returns the word and valid. It is instantiated per row, per column, and (under the macro) per RU with offset r+c.

## Test plan
Defaults apply, with A[r][k]=16r+k and B[k][c]=0x100+16k+c.
- Reset → busy=0, done=0, all valids 0, all data 0. Also rst at FEED n=5 → IDLE next cycle, no done.
- start → n=0: row0=0x0000 valid, rows1–3 invalid. n=3: row0=0x0003, row3=0x0030, col3=0x0103. n=6: only row3=0x0033 and col3=0x0133 valid.
- Full run → FEED 10 cycles, FLUSH 2, done at the 13th cycle after FEED start. Verify against a golden skew model every cycle.
- start held high through the run and in DONE → ignored. The next run begins only after returning to IDLE. Changing input_matrix mid-run does not alter outputs.
- RU_OPERAND_TAP_EN, RU0 → PE(1,2), enabled → n=3: ru_left=0x0010, ru_top=0x0102, valid. n=6: 0x0013/0x0132. n=7: invalid. RU1 disabled → always invalid.
- Back-to-back runs with different matrices → the second run's n=0 row0 equals the new A[0][0]. No state bleeds over from the first run.
